mem_access_unit: RTL and testbench

Multi-cycle data-memory access unit for the MIPS pipeline MEM stage. It accepts one load or store per instruction, checks address alignment, and drives an SRAM-like request/address-ok/data-ok data port. It holds the pipeline with `stall_o` until the access completes, then returns sign/zero-extended or LWL/LWR-merged load data. Compared with a purely combinational MEM stage, it adds handshaked variable-latency memory, flush handling and the unaligned-access instructions.

---
 rtl/mem_access_unit.sv | 118 +++++++++++
 tb/tb_mem_access_unit.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit driving a req/addr_ok/data_ok data port with alignment checks and LWL/LWR/SWL/SWR merges
module mem_access_unit #(
  parameter int UNALIGNED_EN = 1,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              op_valid,
  input  logic [3:0]        op_code,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       rt_data,
  input  logic              ex_in,
  input  logic              flush,
  output logic              stall_o,
  output logic              done_o,
  output logic [31:0]       load_data_o,
  output logic              adel_o,
  output logic              ades_o,
  output logic [ADDR_W-1:0] bad_addr_o,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [3:0]        data_wstrb,
  output logic [ADDR_W-1:0] data_addr,
  output logic [31:0]       data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [31:0]       data_rdata
);
  localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4, OP_LW = 4'd5, OP_LWL = 4'd6, OP_LWR = 4'd7;
  localparam logic [3:0] OP_SB = 4'd8, OP_SH = 4'd9, OP_SW = 4'd10, OP_SWL = 4'd11, OP_SWR = 4'd12;
  localparam bit UA = UNALIGNED_EN != 0;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t state, state_n;
  logic drop, drop_n;
  logic [3:0] op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0] rt_q, m_sh, ld_res;
  logic un_op, is_ld, is_st, mis, go, ld_q, un_q;
  logic [1:0] a;
  logic [4:0] sh_r, sh_l;
  always_comb begin
    un_op = op_code == OP_LWL || op_code == OP_LWR || op_code == OP_SWL || op_code == OP_SWR;
    is_ld = op_code >= OP_LB && op_code <= OP_LWR && (UA || !un_op);
    is_st = op_code >= OP_SB && op_code <= OP_SWR && (UA || !un_op);
    mis = ((op_code == OP_LH || op_code == OP_LHU || op_code == OP_SH) && addr[0]) ||
          ((op_code == OP_LW || op_code == OP_SW) && addr[1:0] != 2'b00);
    go = op_valid && (is_ld || is_st) && !ex_in && !flush && !mis;
    adel_o = !rst && op_valid && !ex_in && is_ld && mis;
    ades_o = !rst && op_valid && !ex_in && is_st && mis;
    bad_addr_o = addr;
    stall_o = !rst && (state == REQ || state == WAIT || (state == IDLE && go));
    done_o = state == DONE;
  end
  always_comb begin
    state_n = state;
    drop_n = drop;
    unique case (state)
      IDLE: state_n = go ? REQ : IDLE;
      REQ: begin
        state_n = data_addr_ok ? WAIT : flush ? IDLE : REQ;
        drop_n = data_addr_ok && flush;
      end
      WAIT: begin
        state_n = data_data_ok ? ((drop || flush) ? IDLE : DONE) : WAIT;
        drop_n = !data_data_ok && (drop || flush);
      end
      DONE: state_n = IDLE;
    endcase
  end
  always_comb begin
    a = addr_q[1:0];
    sh_r = {a, 3'b000};
    sh_l = {~a, 3'b000};
    ld_q = op_q >= OP_LB && op_q <= OP_LWR;
    un_q = op_q == OP_LWL || op_q == OP_LWR || op_q == OP_SWL || op_q == OP_SWR;
    data_req = state == REQ;
    data_wr = op_q >= OP_SB;
    data_addr = un_q ? {addr_q[ADDR_W-1:2], 2'b00} : addr_q;
    data_size = (op_q == OP_LB || op_q == OP_LBU || op_q == OP_SB) ? 2'd0 :
                (op_q == OP_LH || op_q == OP_LHU || op_q == OP_SH) ? 2'd1 : 2'd2;
    data_wstrb = op_q == OP_SB  ? 4'b0001 << a :
                 op_q == OP_SH  ? (a[1] ? 4'b1100 : 4'b0011) :
                 op_q == OP_SW  ? 4'b1111 :
                 op_q == OP_SWL ? 4'b1111 >> ~a :
                 op_q == OP_SWR ? 4'b1111 << a : 4'b0000;
    data_wdata = op_q == OP_SB  ? {4{rt_q[7:0]}} :
                 op_q == OP_SH  ? {2{rt_q[15:0]}} :
                 op_q == OP_SWL ? rt_q >> sh_l :
                 op_q == OP_SWR ? rt_q << sh_r : rt_q;
    m_sh = data_rdata >> sh_r;
    ld_res = op_q == OP_LB  ? {{24{m_sh[7]}}, m_sh[7:0]} :
             op_q == OP_LBU ? {24'h0, m_sh[7:0]} :
             op_q == OP_LH  ? {{16{m_sh[15]}}, m_sh[15:0]} :
             op_q == OP_LHU ? {16'h0, m_sh[15:0]} :
             op_q == OP_LWL ? (data_rdata << sh_l) | (rt_q & ~(32'hFFFF_FFFF << sh_l)) :
             op_q == OP_LWR ? m_sh | (rt_q & ~(32'hFFFF_FFFF >> sh_r)) : data_rdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drop <= 1'b0;
      op_q <= '0;
      addr_q <= '0;
      rt_q <= '0;
      load_data_o <= '0;
    end else begin
      state <= state_n;
      drop <= drop_n;
      if (state == IDLE && go) begin
        op_q <= op_code;
        addr_q <= addr;
        rt_q <= rt_data;
      end
      if (state == WAIT && data_data_ok && !drop && !flush && ld_q) load_data_o <= ld_res;
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: random and directed checks of mem_access_unit against a byte-level memory model
module tb_mem_access_unit;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, op_valid, ex_in, flush;
  logic [3:0] op_code;
  logic [31:0] addr, rt_data;
  logic stall_o, done_o, adel_o, ades_o, data_req, data_wr, data_addr_ok, data_data_ok;
  logic [31:0] load_data_o, bad_addr_o, data_addr, data_wdata, data_rdata;
  logic [1:0] data_size;
  logic [3:0] data_wstrb;
  logic u1_en, u1_valid, u1_stall, u1_done, u1_adel, u1_ades, u1_req, u1_wr;
  logic [31:0] u1_ld, u1_bad, u1_addr, u1_wdata;
  logic [1:0] u1_size;
  logic [3:0] u1_wstrb;
  logic zero = 1'b0;
  logic [31:0] zero32 = '0;
  assign u1_valid = op_valid & u1_en;
  mem_access_unit #(.UNALIGNED_EN(1), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .addr(addr), .rt_data(rt_data),
    .ex_in(ex_in), .flush(flush), .stall_o(stall_o), .done_o(done_o), .load_data_o(load_data_o),
    .adel_o(adel_o), .ades_o(ades_o), .bad_addr_o(bad_addr_o), .data_req(data_req), .data_wr(data_wr),
    .data_size(data_size), .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );
  mem_access_unit #(.UNALIGNED_EN(0), .ADDR_W(32)) u1 (
    .clk(clk), .rst(rst), .op_valid(u1_valid), .op_code(op_code), .addr(addr), .rt_data(rt_data),
    .ex_in(ex_in), .flush(flush), .stall_o(u1_stall), .done_o(u1_done), .load_data_o(u1_ld),
    .adel_o(u1_adel), .ades_o(u1_ades), .bad_addr_o(u1_bad), .data_req(u1_req), .data_wr(u1_wr),
    .data_size(u1_size), .data_wstrb(u1_wstrb), .data_addr(u1_addr), .data_wdata(u1_wdata),
    .data_addr_ok(zero), .data_data_ok(zero), .data_rdata(zero32)
  );
  int checks = 0, errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  logic [7:0] dmem [256];
  logic [7:0] ref_mem [256];
  logic busy, hold, fast, s_wr;
  int cnt, lat_fix, acc_cnt = 0, done_cnt = 0;
  logic [31:0] s_addr, s_wdata;
  logic [3:0] s_wstrb;
  logic [1:0] s_size;
  always @(negedge clk) if (done_o) done_cnt++;
  initial begin
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    data_rdata = '0;
    busy = 1'b0;
    cnt = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        data_addr_ok = 1'b0;
        data_data_ok = 1'b0;
        busy = 1'b0;
      end else begin
        if (data_addr_ok) begin
          data_addr_ok = 1'b0;
          busy = 1'b1;
          cnt = lat_fix >= 0 ? lat_fix : int'($urandom_range(0, 3));
        end else if (!busy && !data_data_ok && data_req && !hold && (fast || $urandom_range(0, 2) == 0)) begin
          data_addr_ok = 1'b1;
          s_addr = data_addr;
          s_wr = data_wr;
          s_wstrb = data_wstrb;
          s_wdata = data_wdata;
          s_size = data_size;
          acc_cnt++;
        end
        if (data_data_ok) data_data_ok = 1'b0;
        else if (busy) begin
          if (cnt == 0) begin
            for (int i = 0; i < 4; i++) begin
              if (s_wr && s_wstrb[i]) dmem[{s_addr[7:2], 2'(i)}] = s_wdata[8*i +: 8];
              data_rdata[8*i +: 8] = dmem[{s_addr[7:2], 2'(i)}];
            end
            data_data_ok = 1'b1;
            busy = 1'b0;
          end else cnt--;
        end
      end
    end
  end
  function automatic logic [31:0] ref_load(input logic [3:0] c, input logic [7:0] a, input logic [31:0] rt);
    logic [31:0] r;
    logic [7:0] b0, b1;
    int off;
    off = int'(a[1:0]);
    r = rt;
    b0 = ref_mem[a];
    b1 = ref_mem[a + 8'd1];
    case (c)
      4'd1: r = {{24{b0[7]}}, b0};
      4'd2: r = {24'h0, b0};
      4'd3: r = {{16{b1[7]}}, b1, b0};
      4'd4: r = {16'h0, b1, b0};
      4'd5: for (int i = 0; i < 4; i++) r[8*i +: 8] = ref_mem[{a[7:2], 2'(i)}];
      4'd6: for (int i = 0; i <= off; i++) r[8*(3-off+i) +: 8] = ref_mem[{a[7:2], 2'(i)}];
      4'd7: for (int i = off; i < 4; i++) r[8*(i-off) +: 8] = ref_mem[{a[7:2], 2'(i)}];
      default: ;
    endcase
    return r;
  endfunction
  task automatic ref_store(input logic [3:0] c, input logic [7:0] a, input logic [31:0] rt);
    int off;
    off = int'(a[1:0]);
    case (c)
      4'd8: ref_mem[a] = rt[7:0];
      4'd9: begin
        ref_mem[a] = rt[7:0];
        ref_mem[a + 8'd1] = rt[15:8];
      end
      4'd10: for (int i = 0; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = rt[8*i +: 8];
      4'd11: for (int i = 0; i <= off; i++) ref_mem[{a[7:2], 2'(i)}] = rt[8*(3-off+i) +: 8];
      4'd12: for (int i = off; i < 4; i++) ref_mem[{a[7:2], 2'(i)}] = rt[8*(i-off) +: 8];
      default: ;
    endcase
  endtask
  task automatic set_word(input logic [7:0] a, input logic [31:0] w);
    for (int i = 0; i < 4; i++) begin
      dmem[{a[7:2], 2'(i)}] = w[8*i +: 8];
      ref_mem[{a[7:2], 2'(i)}] = w[8*i +: 8];
    end
  endtask
  int n_stall;
  logic r_adel, r_ades, r_u1_stall, got_done;
  logic [31:0] r_bad, ld_val;
  task automatic run_op(input logic [3:0] c, input logic [31:0] a, input logic [31:0] rt, input logic exi);
    op_valid = 1'b1;
    op_code = c;
    addr = a;
    rt_data = rt;
    ex_in = exi;
    n_stall = 0;
    #1;
    r_adel = adel_o;
    r_ades = ades_o;
    r_bad = bad_addr_o;
    r_u1_stall = u1_stall;
    for (int i = 0; i < 64 && stall_o; i++) begin
      n_stall++;
      @(negedge clk);
      #1;
    end
    if (stall_o) check("timeout", 32'(stall_o), 32'd0);
    got_done = done_o;
    ld_val = load_data_o;
    @(negedge clk);
    check("req_idle", 32'(data_req), 32'd0);
    op_valid = 1'b0;
    ex_in = 1'b0;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int d0, acc0, nmis;
    logic [31:0] prev_ld, exp_ld, exp_addr, a, rt, w_dut, w_ref;
    logic [3:0] c;
    logic exi, ld, st, mis, go, e_adel, e_ades;
    logic [1:0] exp_size;
    rst = 1'b1;
    op_valid = 1'b1;
    op_code = 4'd3;
    addr = 32'h1;
    rt_data = '0;
    ex_in = 1'b0;
    flush = 1'b0;
    u1_en = 1'b0;
    hold = 1'b0;
    fast = 1'b1;
    lat_fix = 1;
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    repeat (3) @(negedge clk);
    #1;
    check("rst_adel", 32'(adel_o), 32'd0);
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_req", 32'(data_req), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ld", load_data_o, 32'd0);
    rst = 1'b0;
    op_valid = 1'b0;
    @(negedge clk);
    set_word(8'h00, 32'h8081_8283);
    run_op(4'd5, 32'h100, 32'h0, 1'b0);
    check("lw_stall", 32'(n_stall), 32'd4);
    check("lw_done", 32'(got_done), 32'd1);
    check("lw_data", ld_val, 32'h8081_8283);
    check("lw_addr", s_addr, 32'h100);
    run_op(4'd1, 32'h103, 32'h0, 1'b0);
    check("lb_data", ld_val, 32'hFFFF_FF80);
    check("lb_size", 32'(s_size), 32'd0);
    run_op(4'd4, 32'h102, 32'h0, 1'b0);
    check("lhu_data", ld_val, 32'h0000_8081);
    check("lhu_size", 32'(s_size), 32'd1);
    acc0 = acc_cnt;
    run_op(4'd3, 32'h101, 32'h0, 1'b0);
    check("lh_adel", 32'(r_adel), 32'd1);
    check("lh_bad", r_bad, 32'h101);
    check("lh_stall", 32'(n_stall), 32'd0);
    check("lh_noreq", 32'(acc_cnt - acc0), 32'd0);
    run_op(4'd10, 32'h102, 32'h0, 1'b0);
    check("sw_ades", 32'(r_ades), 32'd1);
    check("sw_adel", 32'(r_adel), 32'd0);
    run_op(4'd12, 32'h201, 32'h1122_3344, 1'b0);
    check("swr_strb", 32'(s_wstrb), 32'b1110);
    check("swr_wdata", s_wdata, 32'h2233_4400);
    check("swr_addr", s_addr, 32'h200);
    check("swr_wr", 32'(s_wr), 32'd1);
    u1_en = 1'b1;
    set_word(8'h00, 32'h1122_3344);
    run_op(4'd6, 32'h202, 32'hAABB_CCDD, 1'b0);
    check("lwl_data", ld_val, 32'h2233_44DD);
    check("lwl_addr", s_addr, 32'h200);
    check("u1_stall", 32'(r_u1_stall), 32'd0);
    check("u1_req", 32'(u1_req), 32'd0);
    u1_en = 1'b0;
    acc0 = acc_cnt;
    run_op(4'd5, 32'h104, 32'h0, 1'b1);
    check("ex_stall", 32'(n_stall), 32'd0);
    check("ex_adel", 32'(r_adel), 32'd0);
    check("ex_done", 32'(got_done), 32'd0);
    check("ex_noreq", 32'(acc_cnt - acc0), 32'd0);
    hold = 1'b1;
    d0 = done_cnt;
    op_valid = 1'b1;
    op_code = 4'd5;
    addr = 32'h40;
    @(negedge clk);
    #1;
    check("fr_req", 32'(data_req), 32'd1);
    flush = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("fr_req_drop", 32'(data_req), 32'd0);
    check("fr_stall", 32'(stall_o), 32'd0);
    flush = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    #1;
    check("fr_no_done", 32'(done_cnt - d0), 32'd0);
    lat_fix = 3;
    op_valid = 1'b1;
    op_code = 4'd5;
    addr = 32'h40;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("fw_stall", 32'(stall_o), 32'd1);
    check("fw_req", 32'(data_req), 32'd0);
    flush = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fw_hold", 32'(stall_o), 32'd1);
    for (int i = 0; i < 32 && stall_o; i++) begin
      @(negedge clk);
      #1;
    end
    check("fw_stall_end", 32'(stall_o), 32'd0);
    check("fw_no_done", 32'(done_cnt - d0), 32'd0);
    set_word(8'h40, 32'hCAFE_F00D);
    run_op(4'd5, 32'h40, 32'h0, 1'b0);
    check("fw_next_done", 32'(got_done), 32'd1);
    check("fw_next_data", ld_val, 32'hCAFE_F00D);
    hold = 1'b1;
    op_valid = 1'b1;
    op_code = 4'd5;
    addr = 32'h80;
    @(negedge clk);
    #1;
    check("mr_req", 32'(data_req), 32'd1);
    rst = 1'b1;
    op_valid = 1'b0;
    @(negedge clk);
    #1;
    check("mr_req_off", 32'(data_req), 32'd0);
    check("mr_stall", 32'(stall_o), 32'd0);
    check("mr_ld", load_data_o, 32'd0);
    rst = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dmem[i] = 8'($urandom);
      ref_mem[i] = dmem[i];
    end
    fast = 1'b0;
    lat_fix = -1;
    prev_ld = '0;
    for (int k = 0; k < 300; k++) begin
      c = 4'($urandom_range(0, 15));
      a = $urandom;
      rt = $urandom;
      exi = $urandom_range(0, 9) == 0;
      ld = c >= 4'd1 && c <= 4'd7;
      st = c >= 4'd8 && c <= 4'd12;
      mis = ((c == 4'd3 || c == 4'd4 || c == 4'd9) && a[0]) || ((c == 4'd5 || c == 4'd10) && a[1:0] != 2'b00);
      e_adel = ld && mis && !exi;
      e_ades = st && mis && !exi;
      go = (ld || st) && !mis && !exi;
      exp_addr = (c == 4'd6 || c == 4'd7 || c == 4'd11 || c == 4'd12) ? {a[31:2], 2'b00} : a;
      exp_size = (c == 4'd1 || c == 4'd2 || c == 4'd8) ? 2'd0 : (c == 4'd3 || c == 4'd4 || c == 4'd9) ? 2'd1 : 2'd2;
      exp_ld = ref_load(c, a[7:0], rt);
      acc0 = acc_cnt;
      run_op(c, a, rt, exi);
      check("adel", 32'(r_adel), 32'(e_adel));
      check("ades", 32'(r_ades), 32'(e_ades));
      if (e_adel || e_ades) check("bad_addr", r_bad, a);
      check("done", 32'(got_done), 32'(go));
      check("acc", 32'(acc_cnt - acc0), 32'(go));
      if (go) begin
        check("stall_min", 32'(n_stall >= 3), 32'd1);
        check("req_addr", s_addr, exp_addr);
        check("req_size", 32'(s_size), 32'(exp_size));
        check("req_wr", 32'(s_wr), 32'(st));
      end else check("stall_none", 32'(n_stall), 32'd0);
      if (go && ld) begin
        check("ld_data", ld_val, exp_ld);
        prev_ld = exp_ld;
      end
      if (go && st) begin
        ref_store(c, a[7:0], rt);
        for (int i = 0; i < 4; i++) begin
          w_dut[8*i +: 8] = dmem[{a[7:2], 2'(i)}];
          w_ref[8*i +: 8] = ref_mem[{a[7:2], 2'(i)}];
        end
        check("st_mem", w_dut, w_ref);
        check("st_keep_ld", ld_val, prev_ld);
      end
    end
    nmis = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) nmis++;
    check("mem_final", 32'(nmis), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
